// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command front end.
package uart_cmd_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_CMD  = 3'd1;
  localparam state_t ST_ADDR = 3'd2;
  localparam state_t ST_DATA = 3'd3;
  localparam state_t ST_CSUM = 3'd4;
  localparam state_t ST_HOLD = 3'd5;

  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;
  localparam logic [7:0] ERR_MAX      = 8'hFF;

  // Number of bytes collected in the field owned by a given state.
  function automatic logic [2:0] field_bytes(input state_t st, input int unsigned cmd_b,
                                             input int unsigned addr_b, input int unsigned data_b);
    case (st)
      ST_CMD:  return 3'(cmd_b);
      ST_ADDR: return 3'(addr_b);
      ST_DATA: return 3'(data_b);
      ST_CSUM: return 3'd1;
      default: return 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/uart_cmd_frontend_timeout.sv
// Inter-byte timer: counts enabled cycles without clear, pulses expire on the
// TIMEOUT_CYCLES-th idle cycle. TIMEOUT_CYCLES==0 disables expiry.
module uart_cmd_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 5_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic expire
);

  localparam int unsigned W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [W-1:0] LAST = (TIMEOUT_CYCLES == 0) ? '0 : W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    expire = (TIMEOUT_CYCLES != 0) && enable && !clear && (cnt_q == LAST);
    cnt_d  = (!enable || clear || expire) ? '0 : cnt_q + W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_cmd_frontend.sv
// SYNC-hunting framer: assembles CMD/ADDR/DATA fields into a valid/ready frame.
// Optional checksum byte after DATA is enabled with UART_CMD_CHECKSUM_EN.
//   state | meaning
//   IDLE  | hunting for SYNC_BYTE
//   CMD   | shifting in command bytes
//   ADDR  | shifting in address bytes
//   DATA  | shifting in data bytes
//   CSUM  | expecting XOR of all field bytes
//   HOLD  | frame presented, waiting for frame_ready
module uart_cmd_frontend
  import uart_cmd_pkg::*;
#(
  parameter int unsigned CMD_BYTES      = 1,
  parameter int unsigned ADDR_BYTES     = 4,
  parameter int unsigned DATA_BYTES     = 4,
  parameter logic [7:0]  SYNC_BYTE      = SYNC_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = 5_000_000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [7:0]              rx_data,
  input  logic                    rx_valid,
  output logic [8*CMD_BYTES-1:0]  cmd_out,
  output logic [8*ADDR_BYTES-1:0] addr_out,
  output logic [8*DATA_BYTES-1:0] data_out,
  output logic                    frame_valid,
  input  logic                    frame_ready,
  output logic                    busy,
  output logic                    overrun,
  output logic [7:0]              err_count
);

  localparam int unsigned CW = 8*CMD_BYTES;
  localparam int unsigned AW = 8*ADDR_BYTES;
  localparam int unsigned DW = 8*DATA_BYTES;

  state_t         state_q, state_d;
  logic [1:0]     byte_cnt_q, byte_cnt_d;
  logic [CW-1:0]  cmd_sh_q, cmd_sh_d, cmd_out_q, cmd_out_d;
  logic [AW-1:0]  addr_sh_q, addr_sh_d, addr_out_q, addr_out_d;
  logic [DW-1:0]  data_sh_q, data_sh_d, data_out_q, data_out_d;
  logic           overrun_q, overrun_d;
  logic [7:0]     err_count_q, err_count_d;
`ifdef UART_CMD_CHECKSUM_EN
  logic [7:0]     csum_q, csum_d;
`endif
  logic           err_inc;
  logic           tmo_en, tmo_expire;
  logic [2:0]     n_bytes;
  logic           last_byte;

  assign tmo_en = (state_q == ST_CMD) || (state_q == ST_ADDR) ||
                  (state_q == ST_DATA) || (state_q == ST_CSUM);

  uart_cmd_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .enable (tmo_en),
    .clear  (rx_valid),
    .expire (tmo_expire)
  );

  always_comb begin
    n_bytes   = field_bytes(state_q, CMD_BYTES, ADDR_BYTES, DATA_BYTES);
    last_byte = ({1'b0, byte_cnt_q} == (n_bytes - 3'd1));
  end

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    cmd_sh_d   = cmd_sh_q;
    addr_sh_d  = addr_sh_q;
    data_sh_d  = data_sh_q;
    cmd_out_d  = cmd_out_q;
    addr_out_d = addr_out_q;
    data_out_d = data_out_q;
    overrun_d  = 1'b0;
    err_inc    = 1'b0;
`ifdef UART_CMD_CHECKSUM_EN
    csum_d     = csum_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (rx_valid && (rx_data == SYNC_BYTE)) begin
          state_d    = ST_CMD;
          byte_cnt_d = '0;
`ifdef UART_CMD_CHECKSUM_EN
          csum_d     = '0;
`endif
        end
      end

      ST_CMD, ST_ADDR, ST_DATA: begin
        if (tmo_expire) begin
          state_d    = ST_IDLE;
          byte_cnt_d = '0;
          err_inc    = 1'b1;
        end else if (rx_valid) begin
`ifdef UART_CMD_CHECKSUM_EN
          csum_d = csum_q ^ rx_data;
`endif
          // Truncating the concatenation shifts the new byte in at the LSB end.
          if (state_q == ST_CMD)  cmd_sh_d  = CW'({cmd_sh_q, rx_data});
          if (state_q == ST_ADDR) addr_sh_d = AW'({addr_sh_q, rx_data});
          if (state_q == ST_DATA) data_sh_d = DW'({data_sh_q, rx_data});
          if (last_byte) begin
            byte_cnt_d = '0;
            if (state_q == ST_CMD)       state_d = ST_ADDR;
            else if (state_q == ST_ADDR) state_d = ST_DATA;
            else begin
`ifdef UART_CMD_CHECKSUM_EN
              state_d    = ST_CSUM;
`else
              state_d    = ST_HOLD;
              cmd_out_d  = cmd_sh_q;
              addr_out_d = addr_sh_q;
              data_out_d = data_sh_d;
`endif
            end
          end else begin
            byte_cnt_d = byte_cnt_q + 2'd1;
          end
        end
      end

`ifdef UART_CMD_CHECKSUM_EN
      ST_CSUM: begin
        if (tmo_expire) begin
          state_d = ST_IDLE;
          err_inc = 1'b1;
        end else if (rx_valid) begin
          if (rx_data == csum_q) begin
            state_d    = ST_HOLD;
            cmd_out_d  = cmd_sh_q;
            addr_out_d = addr_sh_q;
            data_out_d = data_sh_q;
          end else begin
            state_d = ST_IDLE;
            err_inc = 1'b1;
          end
        end
      end
`endif

      ST_HOLD: begin
        if (rx_valid) begin
          overrun_d = 1'b1;
          err_inc   = 1'b1;
        end
        if (frame_ready) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase

    err_count_d = (err_inc && (err_count_q != ERR_MAX)) ? err_count_q + 8'd1 : err_count_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      byte_cnt_q  <= '0;
      cmd_sh_q    <= '0;
      addr_sh_q   <= '0;
      data_sh_q   <= '0;
      cmd_out_q   <= '0;
      addr_out_q  <= '0;
      data_out_q  <= '0;
      overrun_q   <= 1'b0;
      err_count_q <= '0;
`ifdef UART_CMD_CHECKSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      cmd_sh_q    <= cmd_sh_d;
      addr_sh_q   <= addr_sh_d;
      data_sh_q   <= data_sh_d;
      cmd_out_q   <= cmd_out_d;
      addr_out_q  <= addr_out_d;
      data_out_q  <= data_out_d;
      overrun_q   <= overrun_d;
      err_count_q <= err_count_d;
`ifdef UART_CMD_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  assign cmd_out     = cmd_out_q;
  assign addr_out    = addr_out_q;
  assign data_out    = data_out_q;
  assign frame_valid = (state_q == ST_HOLD);
  assign busy        = (state_q != ST_IDLE);
  assign overrun     = overrun_q;
  assign err_count   = err_count_q;

endmodule

// File: tb/tb_uart_cmd_frontend.sv
// Directed bench for uart_cmd_frontend; the checksum variant runs when
// UART_CMD_CHECKSUM_EN is defined.
module tb_uart_cmd_frontend;

`ifdef UART_CMD_CHECKSUM_EN
  localparam int CB = 1;
  localparam int AB = 1;
  localparam int DB = 1;
`else
  localparam int CB = 1;
  localparam int AB = 4;
  localparam int DB = 4;
`endif
  localparam int TMO = 100;

  logic              clk;
  logic              reset;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic [8*CB-1:0]   cmd_out;
  logic [8*AB-1:0]   addr_out;
  logic [8*DB-1:0]   data_out;
  logic              frame_valid;
  logic              frame_ready;
  logic              busy;
  logic              overrun;
  logic [7:0]        err_count;

  int checks   = 0;
  int failures = 0;
  int fv_cycles = 0;
  int ov_cycles = 0;

  uart_cmd_frontend #(
    .CMD_BYTES(CB), .ADDR_BYTES(AB), .DATA_BYTES(DB),
    .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .cmd_out(cmd_out), .addr_out(addr_out), .data_out(data_out),
    .frame_valid(frame_valid), .frame_ready(frame_ready), .busy(busy),
    .overrun(overrun), .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_valid === 1'b1) fv_cycles++;
    if (overrun === 1'b1) ov_cycles++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [31:0] c, input logic [31:0] a, input logic [31:0] d);
    send_byte(8'hA5);
    for (int i = CB-1; i >= 0; i--) send_byte(c[8*i +: 8]);
    for (int i = AB-1; i >= 0; i--) send_byte(a[8*i +: 8]);
    for (int i = DB-1; i >= 0; i--) send_byte(d[8*i +: 8]);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_cmd"},   64'(cmd_out), 64'h0);
    check({tag, "_addr"},  64'(addr_out), 64'h0);
    check({tag, "_data"},  64'(data_out), 64'h0);
    check({tag, "_fv"},    64'(frame_valid), 64'h0);
    check({tag, "_busy"},  64'(busy), 64'h0);
    check({tag, "_ovr"},   64'(overrun), 64'h0);
    check({tag, "_err"},   64'(err_count), 64'h0);
  endtask

`ifdef UART_CMD_CHECKSUM_EN
  typedef struct {
    logic [7:0] c;
    logic [7:0] a;
    logic [7:0] d;
    logic [7:0] cs;
    logic       ok;
    logic [7:0] err_after;
  } vec_t;
`else
  typedef struct {
    logic [7:0]  c;
    logic [31:0] a;
    logic [31:0] d;
    int          n_junk;
    logic [7:0]  j0;
    logic [7:0]  j1;
  } vec_t;
`endif

  vec_t vecs[4];

  initial begin
    int fv0;
    int ov0;
    reset       = 1'b1;
    rx_data     = 8'h00;
    rx_valid    = 1'b0;
    frame_ready = 1'b0;
    tick();
    tick();
    check_zero_outputs("reset");
    reset = 1'b0;
    tick();

`ifdef UART_CMD_CHECKSUM_EN
    vecs[0] = '{8'h02, 8'h03, 8'h04, 8'h05, 1'b1, 8'd0};
    vecs[1] = '{8'h02, 8'h03, 8'h04, 8'h00, 1'b0, 8'd1};
    vecs[2] = '{8'hA5, 8'h11, 8'hFF, 8'h4B, 1'b1, 8'd1};
    vecs[3] = '{8'h10, 8'h20, 8'h30, 8'h31, 1'b0, 8'd2};
    frame_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      fv0 = fv_cycles;
      send_frame(32'(vecs[k].c), 32'(vecs[k].a), 32'(vecs[k].d));
      send_byte(vecs[k].cs);
      check("cs_fv", 64'(frame_valid), 64'(vecs[k].ok));
      check("cs_err", 64'(err_count), 64'(vecs[k].err_after));
      if (vecs[k].ok) begin
        check("cs_cmd",  64'(cmd_out), 64'(vecs[k].c));
        check("cs_addr", 64'(addr_out), 64'(vecs[k].a));
        check("cs_data", 64'(data_out), 64'(vecs[k].d));
      end else begin
        check("cs_busy", 64'(busy), 64'h0);
      end
      tick();
      tick();
      check("cs_nframes", 64'(fv_cycles - fv0), 64'(vecs[k].ok));
    end
`else
    // Table: plain frames, leading junk, SYNC values inside fields, all-ones.
    vecs[0] = '{8'h01, 32'h00001020, 32'hDEADBEEF, 0, 8'h00, 8'h00};
    vecs[1] = '{8'h7E, 32'h12345678, 32'h9ABCDEF0, 2, 8'h00, 8'hFF};
    vecs[2] = '{8'hA5, 32'hA5A500A5, 32'h000000A5, 0, 8'h00, 8'h00};
    vecs[3] = '{8'hFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 8'h5A, 8'h00};
    frame_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      fv0 = fv_cycles;
      if (vecs[k].n_junk > 0) send_byte(vecs[k].j0);
      if (vecs[k].n_junk > 1) send_byte(vecs[k].j1);
      if (vecs[k].n_junk > 0) check("junk_busy", 64'(busy), 64'h0);
      send_frame(32'(vecs[k].c), vecs[k].a, vecs[k].d);
      check("tbl_fv",   64'(frame_valid), 64'h1);
      check("tbl_cmd",  64'(cmd_out), 64'(vecs[k].c));
      check("tbl_addr", 64'(addr_out), 64'(vecs[k].a));
      check("tbl_data", 64'(data_out), 64'(vecs[k].d));
      check("tbl_err",  64'(err_count), 64'h0);
      tick();
      check("tbl_fv_drop", 64'(frame_valid), 64'h0);
      check("tbl_nframes", 64'(fv_cycles - fv0), 64'h1);
      check("tbl_cmd_keep", 64'(cmd_out), 64'(vecs[k].c));
    end

    // Held frame with three dropped bytes.
    frame_ready = 1'b0;
    ov0 = ov_cycles;
    send_frame(32'h33, 32'h44556677, 32'h8899AABB);
    for (int i = 0; i < 3; i++) begin
      send_byte(8'hC0 + 8'(i));
      check("ovr_pulse", 64'(overrun), 64'h1);
      tick();
      check("ovr_low", 64'(overrun), 64'h0);
    end
    check("ovr_count", 64'(ov_cycles - ov0), 64'd3);
    check("ovr_err",   64'(err_count), 64'd3);
    check("ovr_fv",    64'(frame_valid), 64'h1);
    check("ovr_cmd",   64'(cmd_out), 64'h33);
    check("ovr_addr",  64'(addr_out), 64'h44556677);
    check("ovr_data",  64'(data_out), 64'h8899AABB);
    frame_ready = 1'b1;
    check("ovr_fv_pre", 64'(frame_valid), 64'h1);
    tick();
    check("ovr_fv_drop", 64'(frame_valid), 64'h0);

    // Byte and accept in the same HOLD cycle: drop counted, transition still taken.
    frame_ready = 1'b0;
    send_frame(32'h01, 32'h02, 32'h03);
    frame_ready = 1'b1;
    send_byte(8'h77);
    check("same_ovr",  64'(overrun), 64'h1);
    check("same_fv",   64'(frame_valid), 64'h0);
    check("same_busy", 64'(busy), 64'h0);
    check("same_err",  64'(err_count), 64'd4);

    // Inter-byte timeout in CMD-complete/ADDR field.
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h00);
    repeat (TMO-1) tick();
    check("tmo_busy_before", 64'(busy), 64'h1);
    check("tmo_err_before",  64'(err_count), 64'd4);
    tick();
    check("tmo_busy_after",  64'(busy), 64'h0);
    check("tmo_err_after",   64'(err_count), 64'd5);
    send_frame(32'h5C, 32'hCAFE0001, 32'h0BADF00D);
    check("tmo_next_fv",   64'(frame_valid), 64'h1);
    check("tmo_next_addr", 64'(addr_out), 64'hCAFE0001);
    check("tmo_next_data", 64'(data_out), 64'h0BADF00D);
    tick();

    // Saturation of the error counter.
    frame_ready = 1'b0;
    send_frame(32'h09, 32'h0A, 32'h0B);
    rx_data  = 8'h55;
    rx_valid = 1'b1;
    repeat (260) tick();
    rx_valid = 1'b0;
    check("err_sat", 64'(err_count), 64'hFF);
    frame_ready = 1'b1;
    tick();
    check("sat_fv_drop", 64'(frame_valid), 64'h0);
`endif

    // Reset in the middle of the address field.
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h11);
    check("mid_busy", 64'(busy), 64'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_zero_outputs("midrst");
    frame_ready = 1'b1;
    send_frame(32'h06, 32'h07, 32'h08);
`ifdef UART_CMD_CHECKSUM_EN
    send_byte(8'h09);
`endif
    check("post_fv",   64'(frame_valid), 64'h1);
    check("post_cmd",  64'(cmd_out), 64'h06);
    check("post_addr", 64'(addr_out), 64'h07);
    check("post_data", 64'(data_out), 64'h08);
    check("post_err",  64'(err_count), 64'h0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_cmd_frontend.md
Name: uart_cmd_frontend

Overview:
Parametrised successor to the fixed 32-bit UART command path. It takes a raw byte stream from the UART receiver and hunts for a SYNC byte. It then assembles a framed command of configurable CMD/ADDR/DATA byte widths and presents it on a valid/ready output interface. Adds inter-byte timeout, overrun detection and an error counter, and sits between RXD and the memory-mapped register/command consumer.

Parameters:
CMD_BYTES, 1, command field width in bytes (1..4)
ADDR_BYTES, 4, address field width in bytes (1..4)
DATA_BYTES, 4, data field width in bytes (1..4)
SYNC_BYTE, 8'hA5, frame start marker
TIMEOUT_CYCLES, 5_000_000, max clk cycles between bytes inside a frame; 0 disables timeout

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
rx_data  input  8  received byte from RXD
rx_valid  input  1  one-cycle strobe, rx_data valid
cmd_out  output  8*CMD_BYTES  assembled command
addr_out  output  8*ADDR_BYTES  assembled address
data_out  output  8*DATA_BYTES  assembled data
frame_valid  output  1  frame available; held until accepted
frame_ready  input  1  consumer accepts frame when high with frame_valid
busy  output  1  high in any state other than IDLE
overrun  output  1  one-cycle pulse: byte dropped while in HOLD
err_count  output  8  saturating count of timeouts, overruns and checksum failures

Behaviour:
- Reset (synchronous, active-high): state=IDLE, byte counter=0, timer=0. All outputs 0, including cmd_out, addr_out, data_out, frame_valid, busy, overrun and err_count. Reset mid-frame discards the partial frame with no err increment.
- States: IDLE -> CMD -> ADDR -> DATA -> [CSUM] -> HOLD -> IDLE.
- IDLE: on rx_valid with rx_data==SYNC_BYTE, go to CMD. Any other byte is ignored without error.
- CMD/ADDR/DATA: each rx_valid shifts the byte in MSB-first (first byte lands in the top byte of the field). Byte counter counts 0..N-1 per field. On the last byte, move to the next state and clear the counter.
- Frame output registers (cmd_out/addr_out/data_out) update only on entry to HOLD. They are stable for the whole HOLD period and keep their last values afterwards.
- HOLD: frame_valid=1. It is asserted the cycle after the final frame byte's rx_valid, so latency is 1 clk. frame_valid&&frame_ready moves to IDLE, and frame_valid drops the next cycle.
- rx_valid in HOLD: the byte is dropped, overrun pulses for 1 cycle and err_count increments. This applies even if frame_ready is high in the same cycle; the transition still occurs.
- A SYNC_BYTE value inside CMD/ADDR/DATA is treated as data (no resync).
- Timeout: in CMD/ADDR/DATA/CSUM, the timer increments each cycle without rx_valid and clears on rx_valid. When the timer reaches TIMEOUT_CYCLES, the state returns to IDLE, the partial frame is discarded and err_count increments. The timer does not run in IDLE or HOLD. Timeout is disabled when TIMEOUT_CYCLES==0.
- err_count saturates at 8'hFF. If two error events occur in the same cycle, it increments by 1.
- busy = (state != IDLE).

Optional Feature:
UART_CMD_CHECKSUM_EN
- Defined:
  - After DATA, the CSUM state expects one byte equal to the XOR of all CMD, ADDR and DATA bytes (SYNC excluded).
  - Match: go to HOLD.
  - Mismatch: return to IDLE, discard the frame, increment err_count; frame_valid is never raised.
- Undefined: the CSUM state and XOR logic are absent, and DATA goes directly to HOLD.

Decomposition:
- Package uart_cmd_pkg:
  - state enum (IDLE, CMD, ADDR, DATA, CSUM, HOLD)
  - default SYNC_BYTE constant
  - ERR_MAX=8'hFF
  - function for field byte count by state
- One natural sub-module, uart_cmd_timeout: a parametrised inter-byte timer with clear/enable inputs and an expire pulse output.
- Byte shifting and the FSM stay in the top module.

Test Plan:
- Defaults, checksum off. Send A5 01 00 00 10 20 DE AD BE EF, frame_ready=1 -> 1 clk after the last byte: frame_valid=1 for one cycle, cmd_out=8'h01, addr_out=32'h00001020, data_out=32'hDEADBEEF, err_count=0.
- Send 00 FF A5 followed by a valid frame -> the leading bytes are ignored, exactly one frame is produced, err_count=0.
- frame_ready=0, complete frame, then send 3 extra bytes -> overrun pulses 3 times, err_count=3, outputs unchanged. Then raise frame_ready -> frame_valid drops 1 cycle later.
- TIMEOUT_CYCLES=100. Send A5 01 00, then wait 100 cycles -> IDLE, busy=0, err_count=1. A following full frame is received correctly.
- UART_CMD_CHECKSUM_EN, CMD_BYTES=1, ADDR_BYTES=1, DATA_BYTES=1. Send A5 02 03 04 05 -> frame accepted (02^03^04=05). Send A5 02 03 04 00 -> no frame_valid, err_count increments by 1.
- Assert reset in the middle of the ADDR field -> next cycle all outputs are 0 and state is IDLE. A fresh frame then decodes normally.
